// File: rtl/uart_bus_if.sv
// CPU strobe/ack register bus as seen by the UART peripheral.
interface uart_bus_if;
    logic [31:0] dat_i;
    logic [31:0] adr_i;
    logic        we_i;
    logic        stb_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (output dat_i, adr_i, we_i, stb_i, input dat_o, ack_o);
    modport slave  (input dat_i, adr_i, we_i, stb_i, output dat_o, ack_o);
endinterface

// File: rtl/uart_csr_fifo.sv
// UART peripheral: 8N1 transceiver (16x oversampled) behind the register bus,
// with RX/TX FIFOs, status, interrupts, overrun detection, flush and loopback.

module uart_transceiver (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] divisor,
    input  logic        rx,
    output logic        tx,
    output logic [7:0]  rx_data,
    output logic        rx_done,
    input  logic [7:0]  tx_data,
    input  logic        tx_wr,
    output logic        tx_busy
);
    logic [15:0] div_m1, rx_div, tx_div;
    logic [1:0]  rx_sync;
    logic        rx_busy;
    logic [3:0]  rx_os, rx_bit, tx_os, tx_bit;
    logic [7:0]  rx_sh;
    logic [9:0]  tx_sh;
    logic        rx_s;

    // divisor 0 behaves as 1 so the oversample tick never stalls
    assign div_m1 = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    assign rx_s   = rx_sync[1];

    // RX: synchronise, find start edge, sample each bit centre, check stop bit
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_sync <= 2'b11;
            rx_busy <= 1'b0;
            rx_div  <= '0;
            rx_os   <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            rx_done <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_done <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s) begin
                    rx_busy <= 1'b1;
                    rx_os   <= '0;
                    rx_bit  <= '0;
                    rx_div  <= div_m1;
                end
            end else if (rx_div != 16'd0) begin
                rx_div <= rx_div - 16'd1;
            end else begin
                rx_div <= div_m1;
                rx_os  <= rx_os + 4'd1;
                if (rx_bit == 4'd0 && rx_os == 4'd7) begin
                    // mid start bit: a glitch back to idle aborts the frame
                    if (rx_s) rx_busy <= 1'b0;
                    else begin
                        rx_bit <= 4'd1;
                        rx_os  <= '0;
                    end
                end else if (rx_bit != 4'd0 && rx_os == 4'd15) begin
                    if (rx_bit == 4'd9) begin
                        rx_busy <= 1'b0;
                        if (rx_s) begin
                            rx_done <= 1'b1;
                            rx_data <= rx_sh;
                        end
                    end else begin
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_bit <= rx_bit + 4'd1;
                    end
                end
            end
        end
    end

    // TX: start bit goes out on the edge after tx_wr, then data LSB first, then stop
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_sh   <= '1;
            tx_div  <= '0;
            tx_os   <= '0;
            tx_bit  <= '0;
        end else if (tx_wr && !tx_busy) begin
            tx_sh   <= {1'b1, tx_data, 1'b0};
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            tx_div  <= div_m1;
            tx_os   <= '0;
            tx_bit  <= '0;
        end else if (tx_busy) begin
            if (tx_div != 16'd0) begin
                tx_div <= tx_div - 16'd1;
            end else begin
                tx_div <= div_m1;
                tx_os  <= tx_os + 4'd1;
                if (tx_os == 4'd15) begin
                    if (tx_bit == 4'd9) begin
                        tx_busy <= 1'b0;
                        tx      <= 1'b1;
                    end else begin
                        tx_sh  <= {1'b1, tx_sh[9:1]};
                        tx     <= tx_sh[1];
                        tx_bit <= tx_bit + 4'd1;
                    end
                end
            end
        end
    end
endmodule

module uart_csr_fifo #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic      sys_clk,
    input  logic      sys_rst,
    uart_bus_if.slave bus,
    output logic      rx_irq,
    output logic      tx_irq,
    output logic      err_irq,
    input  logic      uart_rx,
    output logic      uart_tx
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam logic [15:0] DEF_DIV = 16'(CLK_FREQ / (BAUD * 16));

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_SEND} tx_state_t;

    logic [15:0] div_q;
    logic        thru, loop_en, rx_ie, tx_ie, err_ie, ovr, acc_q;
    logic [7:0]  rx_thr, tx_thr, rx_thr_eff, rx_count, tx_count;
    logic [2:0]  adr;
    logic        fire, wr_en, rx_flush, tx_flush;
    logic [31:0] rd_data;

    logic [7:0]  rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [RAW:0]   rx_cnt;
    logic        rx_empty, rx_full, rx_push, rx_pop, rx_ovf;

    logic [7:0]  tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp, tx_rp;
    logic [TAW:0]   tx_cnt;
    logic        tx_empty, tx_full, tx_push, tx_pop, tx_active;

    tx_state_t   tx_state;
    logic        tx_wr, tx_busy, rx_done, xcvr_tx, xcvr_rx;
    logic [7:0]  tx_byte, rx_data;
    logic        unused_bits;

    assign unused_bits = ^{bus.adr_i[31:3], bus.dat_i[31:16]};
    assign adr         = bus.adr_i[2:0];
    assign bus.ack_o   = bus.stb_i & ~(bus.we_i & (adr == 3'd0) & tx_full);
    assign fire        = bus.stb_i & bus.ack_o & ~acc_q;
    assign wr_en       = fire & bus.we_i;
    assign rx_flush    = wr_en & (adr == 3'd2) & bus.dat_i[5];
    assign tx_flush    = wr_en & (adr == 3'd2) & bus.dat_i[6];

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == (RAW+1)'(RX_DEPTH));
    assign rx_pop   = fire & ~bus.we_i & (adr == 3'd0) & ~rx_empty;
    assign rx_push  = rx_done & (~rx_full | rx_pop);
    assign rx_ovf   = rx_done & rx_full & ~rx_pop & ~rx_flush;
    assign rx_count = 8'(rx_cnt);

    assign tx_empty  = (tx_cnt == '0);
    assign tx_full   = (tx_cnt == (TAW+1)'(TX_DEPTH));
    assign tx_push   = wr_en & (adr == 3'd0);
    assign tx_pop    = (tx_state == TX_IDLE) & ~tx_empty & ~tx_busy & ~tx_flush;
    assign tx_count  = 8'(tx_cnt);
    assign tx_active = (tx_state != TX_IDLE);

    assign rx_thr_eff = (rx_thr == 8'd0) ? 8'd1 : rx_thr;
    assign rx_irq  = rx_ie & (rx_count >= rx_thr_eff);
    assign tx_irq  = tx_ie & (tx_count <= tx_thr);
    assign err_irq = err_ie & ovr;

    // loop feeds TX back to RX and parks the pin idle; thru bridges the pins
    assign xcvr_rx = loop_en ? xcvr_tx : uart_rx;
    assign uart_tx = loop_en ? 1'b1 : (thru ? uart_rx : xcvr_tx);

    uart_transceiver u_xcvr (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .divisor (div_q),
        .rx      (xcvr_rx),
        .tx      (xcvr_tx),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .tx_data (tx_byte),
        .tx_wr   (tx_wr),
        .tx_busy (tx_busy)
    );

    // read mux for the addressed register
    always_comb begin
        rd_data = '0;
        case (adr)
            3'd0: if (!rx_empty) rd_data = {23'h0, 1'b1, rx_mem[rx_rp]};
            3'd1: rd_data = {16'h0, div_q};
            3'd2: rd_data = {27'h0, err_ie, tx_ie, rx_ie, loop_en, thru};
            3'd3: rd_data = {8'h0, tx_count, rx_count, 2'b00, ovr,
                             tx_active, tx_full, tx_empty, rx_full, rx_empty};
            3'd4: rd_data = {16'h0, tx_thr, rx_thr};
            default: rd_data = '0;
        endcase
    end

    // bus registers; acc_q makes each strobe assertion act exactly once
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            acc_q   <= 1'b0;
            bus.dat_o <= '0;
            div_q   <= DEF_DIV;
            {err_ie, tx_ie, rx_ie, loop_en, thru} <= '0;
            rx_thr  <= 8'd1;
            tx_thr  <= 8'd0;
            ovr     <= 1'b0;
        end else begin
            acc_q <= bus.stb_i & bus.ack_o;
            if (fire) bus.dat_o <= rd_data;
            if (wr_en) begin
                case (adr)
                    3'd1: div_q <= bus.dat_i[15:0];
                    3'd2: {err_ie, tx_ie, rx_ie, loop_en, thru} <= bus.dat_i[4:0];
                    3'd4: {tx_thr, rx_thr} <= bus.dat_i[15:0];
                    default: ;
                endcase
            end
            if (rx_ovf) ovr <= 1'b1;
            else if (wr_en && adr == 3'd3 && bus.dat_i[5]) ovr <= 1'b0;
        end
    end

    // RX FIFO pointers/count; flush wins over same-cycle push/pop
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
        end else if (rx_flush) begin
            rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RAW'(1);
            if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + (RAW+1)'(1);
            else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - (RAW+1)'(1);
        end
    end

    // RX FIFO storage
    always_ff @(posedge sys_clk) begin
        if (rx_push && !rx_flush) rx_mem[rx_wp] <= rx_data;
    end

    // TX FIFO pointers/count; flush wins over same-cycle push/pop
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
        end else if (tx_flush) begin
            tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TAW'(1);
            if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + (TAW+1)'(1);
            else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - (TAW+1)'(1);
        end
    end

    // TX FIFO storage
    always_ff @(posedge sys_clk) begin
        if (tx_push && !tx_flush) tx_mem[tx_wp] <= bus.dat_i[7:0];
    end

    // TX feeder: hand the head byte over, then track the transceiver busy window
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tx_state <= TX_IDLE;
            tx_wr    <= 1'b0;
            tx_byte  <= '0;
        end else begin
            tx_wr <= 1'b0;
            case (tx_state)
                TX_IDLE: if (tx_pop) begin
                    tx_wr    <= 1'b1;
                    tx_byte  <= tx_mem[tx_rp];
                    tx_state <= TX_START;
                end
                TX_START: if (tx_busy)  tx_state <= TX_SEND;
                TX_SEND:  if (!tx_busy) tx_state <= TX_IDLE;
                default:  tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_csr_fifo.sv
// Directed bench for uart_csr_fifo with 4-entry FIFOs and divisor 1 (160-cycle frames).
module tb_uart_csr_fifo;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx, rx_irq, tx_irq, err_irq;
    int   checks = 0;
    int   errors = 0;
    logic mon_tx = 1'b0;
    int   tx_low_cnt = 0;

    uart_bus_if bus();

    uart_csr_fifo #(.CLK_FREQ(100000000), .BAUD(115200), .RX_DEPTH(4), .TX_DEPTH(4)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus),
        .rx_irq  (rx_irq),
        .tx_irq  (tx_irq),
        .err_irq (err_irq),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 sys_clk = ~sys_clk;

    // counts cycles where the pin left idle while monitoring is on
    always @(negedge sys_clk) if (mon_tx && uart_tx !== 1'b1) tx_low_cnt++;

    task automatic bus_xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                            output logic [31:0] q);
        int n;
        @(negedge sys_clk);
        bus.adr_i = {29'h0, a}; bus.dat_i = d; bus.we_i = we; bus.stb_i = 1'b1;
        n = 0;
        while (bus.ack_o !== 1'b1 && n < 2000) begin @(negedge sys_clk); n++; end
        if (bus.ack_o !== 1'b1) begin
            checks++; errors++;
            $display("FAIL bus_ack_timeout adr=%0d ack=%b required 1", a, bus.ack_o);
        end
        @(negedge sys_clk);
        q = bus.dat_o;
        bus.stb_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus_xfer(1'b1, a, d, q);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] q);
        bus_xfer(1'b0, a, 32'h0, q);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk); uart_rx = 1'b0; repeat (16) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (16) @(negedge sys_clk); end
        uart_rx = 1'b1; repeat (20) @(negedge sys_clk);
    endtask

    // polls STAT until (stat & mask) == val or the budget runs out
    task automatic wait_stat(input logic [31:0] mask, input logic [31:0] val, output logic ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            rd(3'd3, s);
            if ((s & mask) == val) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] q;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (uart_tx !== 1'b1 || bus.dat_o !== 32'h0 || {rx_irq, tx_irq, err_irq} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs tx=%b dat_o=%h irqs=%b required 1/0/000",
                     uart_tx, bus.dat_o, {rx_irq, tx_irq, err_irq});
        end
        sys_rst = 1'b0;
        rd(3'd1, q); checks++;
        if (q !== 32'd54) begin errors++; $display("FAIL reset_div got %h required 00000036", q); end
        rd(3'd3, q); checks++;
        if (q !== 32'h5) begin errors++; $display("FAIL reset_stat got %h required 00000005", q); end
        rd(3'd2, q); checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h required 00000000", q); end
        rd(3'd4, q); checks++;
        if (q !== 32'h1) begin errors++; $display("FAIL reset_thr got %h required 00000001", q); end
        rd(3'd6, q); checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h required 00000000", q); end
        wr(3'd1, 32'd1);
        rd(3'd1, q); checks++;
        if (q !== 32'd1) begin errors++; $display("FAIL div_write got %h required 00000001", q); end
    endtask

    task automatic test_loopback;
        logic [31:0] q;
        logic ok;
        wr(3'd2, 32'h2);
        mon_tx = 1'b1;
        wr(3'd0, 32'h41); wr(3'd0, 32'h42); wr(3'd0, 32'h43);
        wait_stat(32'h0000FF00, 32'h00000300, ok); checks++;
        if (!ok) begin errors++; $display("FAIL loop_rx_count got timeout required 3"); end
        rd(3'd0, q); checks++;
        if (q !== 32'h141) begin errors++; $display("FAIL loop_rd0 got %h required 00000141", q); end
        rd(3'd0, q); checks++;
        if (q !== 32'h142) begin errors++; $display("FAIL loop_rd1 got %h required 00000142", q); end
        rd(3'd0, q); checks++;
        if (q !== 32'h143) begin errors++; $display("FAIL loop_rd2 got %h required 00000143", q); end
        rd(3'd0, q); checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL loop_rd_empty got %h required 00000000", q); end
        wait_stat(32'h1C, 32'h04, ok);
        mon_tx = 1'b0;
        checks++;
        if (tx_low_cnt !== 0) begin errors++; $display("FAIL loop_pin_idle got %0d low cycles required 0", tx_low_cnt); end
        wr(3'd2, 32'h0);
    endtask

    task automatic test_tx_stall;
        logic [31:0] q;
        logic ok;
        int stall;
        wr(3'd0, 32'h01);
        repeat (4) @(negedge sys_clk);
        // one strobe held for 10 cycles must push a single byte
        bus.adr_i = 32'h0; bus.dat_i = 32'h02; bus.we_i = 1'b1; bus.stb_i = 1'b1;
        repeat (10) @(negedge sys_clk);
        bus.stb_i = 1'b0; bus.we_i = 1'b0;
        rd(3'd3, q); checks++;
        if (q !== 32'h00010011) begin errors++; $display("FAIL held_stb_stat got %h required 00010011", q); end
        wr(3'd0, 32'h03); wr(3'd0, 32'h04); wr(3'd0, 32'h05);
        rd(3'd3, q); checks++;
        if (q !== 32'h00040019) begin errors++; $display("FAIL tx_full_stat got %h required 00040019", q); end
        @(negedge sys_clk);
        bus.adr_i = 32'h0; bus.dat_i = 32'h06; bus.we_i = 1'b1; bus.stb_i = 1'b1;
        stall = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ack_o === 1'b0) stall++;
            @(negedge sys_clk);
        end
        checks++;
        if (stall !== 20) begin errors++; $display("FAIL tx_stall_ack got %0d low cycles required 20", stall); end
        for (int n = 0; n < 400 && bus.ack_o !== 1'b1; n++) @(negedge sys_clk);
        checks++;
        if (bus.ack_o !== 1'b1) begin errors++; $display("FAIL tx_stall_release got ack=%b required 1", bus.ack_o); end
        @(negedge sys_clk);
        bus.stb_i = 1'b0; bus.we_i = 1'b0;
        rd(3'd3, q); checks++;
        if ((q & 32'h00FF0008) !== 32'h00040008) begin
            errors++; $display("FAIL tx_after_stall got %h required tx_count=4 tx_full=1", q);
        end
        wait_stat(32'h1C, 32'h04, ok); checks++;
        if (!ok) begin errors++; $display("FAIL tx_drain got timeout required tx idle"); end
    endtask

    task automatic test_overrun;
        logic [31:0] q;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        rd(3'd3, q); checks++;
        if (q !== 32'h00000426) begin errors++; $display("FAIL ovr_stat got %h required 00000426", q); end
        wr(3'd2, 32'h10);
        @(negedge sys_clk); checks++;
        if (err_irq !== 1'b1) begin errors++; $display("FAIL err_irq_set got %b required 1", err_irq); end
        wr(3'd3, 32'h20);
        checks++;
        if (err_irq !== 1'b0) begin errors++; $display("FAIL err_irq_clear got %b required 0", err_irq); end
        rd(3'd3, q); checks++;
        if (q !== 32'h00000406) begin errors++; $display("FAIL ovr_clear_stat got %h required 00000406", q); end
        rd(3'd0, q); checks++;
        if (q !== 32'h111) begin errors++; $display("FAIL ovr_rd0 got %h required 00000111", q); end
        rd(3'd0, q); checks++;
        if (q !== 32'h122) begin errors++; $display("FAIL ovr_rd1 got %h required 00000122", q); end
        rd(3'd0, q); checks++;
        if (q !== 32'h133) begin errors++; $display("FAIL ovr_rd2 got %h required 00000133", q); end
        rd(3'd0, q); checks++;
        if (q !== 32'h144) begin errors++; $display("FAIL ovr_rd3 got %h required 00000144", q); end
    endtask

    task automatic test_thresholds;
        logic [31:0] q;
        int n;
        wr(3'd4, 32'h0003);
        wr(3'd2, 32'h0C);
        checks++;
        if (tx_irq !== 1'b1) begin errors++; $display("FAIL tx_irq_empty got %b required 1", tx_irq); end
        wr(3'd2, 32'h04);
        send_byte(8'hA1); send_byte(8'hA2);
        checks++;
        if (rx_irq !== 1'b0) begin errors++; $display("FAIL rx_irq_two got %b required 0", rx_irq); end
        send_byte(8'hA3);
        checks++;
        if (rx_irq !== 1'b1) begin errors++; $display("FAIL rx_irq_three got %b required 1", rx_irq); end
        wr(3'd2, 32'h24);
        checks++;
        if (rx_irq !== 1'b0) begin errors++; $display("FAIL rx_irq_flush got %b required 0", rx_irq); end
        rd(3'd3, q); checks++;
        if (q !== 32'h5) begin errors++; $display("FAIL rx_flush_stat got %h required 00000005", q); end
        rd(3'd2, q); checks++;
        if (q !== 32'h4) begin errors++; $display("FAIL ctrl_flush_bits got %h required 00000004", q); end
        send_byte(8'hB1);
        // flush lands in the very cycle the next byte completes
        fork
            send_byte(8'hB2);
            begin
                n = 0;
                while (dut.rx_done !== 1'b1 && n < 400) begin @(negedge sys_clk); n++; end
                bus.adr_i = 32'h2; bus.dat_i = 32'h24; bus.we_i = 1'b1; bus.stb_i = 1'b1;
                @(negedge sys_clk);
                bus.stb_i = 1'b0; bus.we_i = 1'b0;
            end
        join
        rd(3'd3, q); checks++;
        if (q !== 32'h5) begin errors++; $display("FAIL flush_vs_push got %h required 00000005", q); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] q;
        wr(3'd2, 32'h0);
        wr(3'd0, 32'h00);
        rd(3'd1, q);
        repeat (3) @(negedge sys_clk);
        checks++;
        if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_start got %b required 0", uart_tx); end
        @(posedge sys_clk); #2 sys_rst = 1'b1; #1;
        checks++;
        if (uart_tx !== 1'b1 || bus.dat_o !== 32'h0) begin
            errors++; $display("FAIL async_reset got tx=%b dat_o=%h required 1/00000000", uart_tx, bus.dat_o);
        end
        @(negedge sys_clk); sys_rst = 1'b0;
        rd(3'd1, q); checks++;
        if (q !== 32'd54) begin errors++; $display("FAIL rst2_div got %h required 00000036", q); end
        rd(3'd3, q); checks++;
        if (q !== 32'h5) begin errors++; $display("FAIL rst2_stat got %h required 00000005", q); end
        checks++;
        if ({rx_irq, tx_irq, err_irq} !== 3'b000 || uart_tx !== 1'b1) begin
            errors++; $display("FAIL rst2_outputs got irqs=%b tx=%b required 000/1", {rx_irq, tx_irq, err_irq}, uart_tx);
        end
    endtask

    initial begin
        bus.adr_i = '0; bus.dat_i = '0; bus.we_i = 1'b0; bus.stb_i = 1'b0;
        test_reset;
        test_loopback;
        test_tx_stall;
        test_overrun;
        test_thresholds;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
